// File: rtl/led_pkg.sv
// Shared definitions for the LED matrix scan blocks:
// default geometry, scan state encoding and a width helper.
package led_pkg;

    localparam int NROWS_DEF = 7;
    localparam int NCOLS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_e;

    // Bits needed to hold 0..v-1, never less than one bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/led_scan_mux_if.sv
// Bundle between the PWM glow generator, the scan mux
// and the matrix pins.
interface led_scan_if #(
    parameter int NROWS = led_pkg::NROWS_DEF,
    parameter int NCOLS = led_pkg::NCOLS_DEF
) ();
    import led_pkg::*;

    localparam int RW = clog2(NROWS);

    logic                   en;
    logic [NROWS*NCOLS-1:0] in;
    logic [NROWS-1:0]       row_n;
    logic [NCOLS-1:0]       col;
    logic                   frame_start;
    logic [RW-1:0]          row_idx;

    modport master (
        output en, in,
        input  row_n, col, frame_start, row_idx
    );

    modport slave (
        input  en, in,
        output row_n, col, frame_start, row_idx
    );

endinterface

// File: rtl/led_scan_timer.sv
// Loadable down-counter; tc is high while the count is zero.
// Holds at zero rather than wrapping.
module led_scan_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    // Load on request, otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/led_scan_mux.sv
// Row/column scan of the flat LED drive vector with
// active-low row strobes and inter-row blanking.
module led_scan_mux
    import led_pkg::*;
#(
    parameter int NROWS = NROWS_DEF,
    parameter int NCOLS = NCOLS_DEF,
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input logic     clk,
    input logic     rst_n,
    led_scan_if.slave bus
);

    localparam int RW   = clog2(NROWS);
    localparam int TMX  = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW   = clog2((TMX > 2) ? TMX : 2);
    localparam int NB   = NROWS * NCOLS;

    localparam logic [TW-1:0] DW_LD = TW'(DWELL - 1);
    localparam logic [TW-1:0] BL_LD = TW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [RW-1:0] LAST  = RW'(NROWS - 1);

    scan_state_e      state;
    logic [RW-1:0]    row_idx;
    logic [RW-1:0]    row_nxt;
    logic [NROWS-1:0] row_n;
    logic [NCOLS-1:0] col;
    logic             frame_start;
    logic             t_load;
    logic [TW-1:0]    t_val;
    logic             t_tc;

    function automatic logic [NROWS-1:0] strobe(input logic [RW-1:0] r);
        return ~(NROWS'(1) << r);
    endfunction

    function automatic logic [NCOLS-1:0] slice(
        input logic [NB-1:0] v,
        input logic [RW-1:0] r
    );
        return v[int'(r)*NCOLS +: NCOLS];
    endfunction

    assign row_nxt = (row_idx == LAST) ? '0 : row_idx + RW'(1);

    // Reload the timer on every state change; idle holds it at zero.
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        if (!bus.en) begin
            t_load = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    t_load = 1'b1;
                    t_val  = (BLANK > 0) ? BL_LD : DW_LD;
                end
                ST_BLANK: begin
                    t_load = t_tc;
                    t_val  = DW_LD;
                end
                ST_DRIVE: begin
                    t_load = t_tc;
                    t_val  = (BLANK > 0) ? BL_LD : DW_LD;
                end
                default: begin
                    t_load = 1'b1;
                end
            endcase
        end
    end

    led_scan_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .tc       (t_tc)
    );

    // Scan FSM; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.en) begin
            state       <= ST_IDLE;
            row_idx     <= '0;
            row_n       <= '1;
            col         <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    row_idx <= '0;
                    if (BLANK > 0) begin
                        state <= ST_BLANK;
                        row_n <= '1;
                        col   <= '0;
                    end else begin
                        state       <= ST_DRIVE;
                        row_n       <= strobe('0);
                        col         <= slice(bus.in, '0);
                        frame_start <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (t_tc) begin
                        state       <= ST_DRIVE;
                        row_n       <= strobe(row_idx);
                        col         <= slice(bus.in, row_idx);
                        frame_start <= (row_idx == '0);
                    end
                end
                ST_DRIVE: begin
                    if (!t_tc) begin
                        col <= slice(bus.in, row_idx);
                    end else begin
                        row_idx <= row_nxt;
                        if (BLANK > 0) begin
                            state <= ST_BLANK;
                            row_n <= '1;
                            col   <= '0;
                        end else begin
                            row_n       <= strobe(row_nxt);
                            col         <= slice(bus.in, row_nxt);
                            frame_start <= (row_nxt == '0);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    row_idx <= '0;
                    row_n   <= '1;
                    col     <= '0;
                end
            endcase
        end
    end

    assign bus.row_n       = row_n;
    assign bus.col         = col;
    assign bus.frame_start = frame_start;
    assign bus.row_idx     = row_idx;

endmodule

// File: tb/tb_led_scan_mux.sv
// Scoreboard bench: two scan muxes (blanked and unblanked)
// share clock, reset and stimulus.
module tb_led_scan_mux;

    typedef struct packed {
        logic [6:0] rn;
        logic [7:0] col;
        logic       fs;
        logic [2:0] ri;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   ka;
    int   kb;
    exp_t qa[$];
    exp_t qb[$];

    led_scan_if #(.NROWS(7), .NCOLS(8)) ifa ();
    led_scan_if #(.NROWS(7), .NCOLS(8)) ifb ();

    led_scan_mux #(.NROWS(7), .NCOLS(8), .DWELL(4), .BLANK(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    led_scan_mux #(.NROWS(7), .NCOLS(8), .DWELL(1), .BLANK(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs k cycles after enable, from the frame timing.
    function automatic exp_t model(
        input int k, input int d, input int b, input logic [55:0] v
    );
        exp_t e;
        int p, r, off;
        p   = k % (7 * (d + b));
        r   = p / (d + b);
        off = p % (d + b);
        e.ri = 3'(r);
        if (off >= b) begin
            e.rn  = ~(7'(1) << r);
            e.col = v[r*8 +: 8];
            e.fs  = (r == 0) && (off == b);
        end else begin
            e.rn  = '1;
            e.col = '0;
            e.fs  = 1'b0;
        end
        return e;
    endfunction

    task automatic step(input logic e, input logic r, input logic [55:0] v);
        exp_t dark;
        dark = '{rn: 7'h7F, col: 8'h00, fs: 1'b0, ri: 3'd0};
        @(negedge clk);
        rst_n  = r;
        ifa.en = e;
        ifb.en = e;
        ifa.in = v;
        ifb.in = v;
        if (!r || !e) begin
            qa.push_back(dark);
            qb.push_back(dark);
            ka = 0;
            kb = 0;
        end else begin
            qa.push_back(model(ka, 4, 2, v));
            qb.push_back(model(kb, 1, 0, v));
            ka++;
            kb++;
        end
    endtask

    task automatic check(input string nm, input exp_t got, input exp_t e);
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got rn=%h col=%h fs=%b ri=%0d exp rn=%h col=%h fs=%b ri=%0d",
                     nm, $time, got.rn, got.col, got.fs, got.ri,
                     e.rn, e.col, e.fs, e.ri);
        end
        n_cmp++;
        if ($countones(~got.rn) > 1) begin
            n_bad++;
            $display("FAIL %s_onehot t=%0t got rn=%h exp at most one low", nm, $time, got.rn);
        end
    endtask

    // Monitor: compare each registered output against the queue head.
    always @(posedge clk) begin
        #1;
        if (qa.size() > 0)
            check("dut_a", {ifa.row_n, ifa.col, ifa.frame_start, ifa.row_idx}, qa.pop_front());
        if (qb.size() > 0)
            check("dut_b", {ifb.row_n, ifb.col, ifb.frame_start, ifb.row_idx}, qb.pop_front());
    end

    initial begin
        logic [55:0] ones;
        logic [55:0] hot;
        n_cmp  = 0;
        n_bad  = 0;
        ka     = 0;
        kb     = 0;
        rst_n  = 1'b0;
        ifa.en = 1'b0;
        ifb.en = 1'b0;
        ifa.in = '0;
        ifb.in = '0;
        ones   = '1;
        hot    = 56'(1) << (6*8 + 3);

        // reset
        step(0, 0, '0);
        step(0, 0, '0);
        step(0, 1, '0);

        // all lit, first rows
        for (int i = 0; i < 14; i++) step(1, 1, ones);
        step(0, 1, ones);

        // two frames with a single LED in row 6
        for (int i = 0; i < 90; i++) step(1, 1, hot);
        step(0, 1, hot);

        // live column data toggling every cycle
        for (int i = 0; i < 10; i++)
            step(1, 1, {48'h5A5A_0F0F_C3C3, 7'h2B, 1'(i % 2)});
        step(0, 1, '0);

        // en drop mid row 1, then re-enable
        for (int i = 0; i < 10; i++) step(1, 1, 56'h12_3456_789A_BCDE);
        step(0, 1, 56'h12_3456_789A_BCDE);
        for (int i = 0; i < 12; i++) step(1, 1, 56'hFE_DCBA_9876_5432);

        // reset pulse mid-scan with en held
        step(0, 1, '0);
        for (int i = 0; i < 20; i++) step(1, 1, 56'hA5_A5A5_A5A5_A5A5);
        step(1, 0, 56'hA5_A5A5_A5A5_A5A5);
        for (int i = 0; i < 16; i++) step(1, 1, 56'h3C_C33C_C33C_C33C);

        // drain, bounded
        for (int i = 0; i < 3; i++) @(negedge clk);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d/%0d pending exp 0", qa.size(), qb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
